spi_pixel_writer: RTL and testbench



---
 rtl/spi_pixel_writer.sv | 150 +++++++++++++++
 tb/tb_spi_pixel_writer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pixel_writer.sv
// Decodes the SPI byte stream into framebuffer pixel writes, whole-buffer fills
// and display refresh requests for a WS2812B chain.
module spi_pixel_writer #(
    parameter int NUM_LEDS = 64,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_idle,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [23:0]       mem_wdata,
    output logic              frame_show,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [3:0] {
        S_CMD,
        S_ADDR,
        S_RED,
        S_GRN,
        S_BLU,
        S_FR,
        S_FG,
        S_FB,
        S_FILLING,
        S_DISCARD
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_LEDS - 1);

    state_t            state, state_nx, cur;
    logic [ADDR_W-1:0] ptr, ptr_nx, addr_nx, start_addr;
    logic [7:0]        red, red_nx, grn, grn_nx;
    logic [23:0]       wdata_nx;
    logic              we_nx, show_nx, busy_nx, overrun_nx;

    always_comb begin
        start_addr = byte_data[ADDR_W-1:0];
        if (int'(start_addr) >= NUM_LEDS) begin
            start_addr = '0;
        end
    end

    always_comb begin
        ptr_nx     = ptr;
        red_nx     = red;
        grn_nx     = grn;
        addr_nx    = mem_addr;
        wdata_nx   = mem_wdata;
        we_nx      = 1'b0;
        show_nx    = 1'b0;
        busy_nx    = 1'b0;
        overrun_nx = overrun;
        // Idle restarts the transaction, so a byte arriving with idle is a command.
        cur        = (byte_idle && state != S_FILLING) ? S_CMD : state;
        state_nx   = cur;

        if (cur == S_FILLING) begin
            // mem_addr doubles as the fill counter; mem_data stays at the fill colour.
            overrun_nx = overrun | byte_valid;
            if (mem_addr == LAST) begin
                state_nx = S_DISCARD;
            end else begin
                we_nx   = 1'b1;
                busy_nx = 1'b1;
                addr_nx = mem_addr + 1'b1;
            end
        end else if (byte_valid) begin
            unique case (cur)
                S_CMD: begin
                    unique case (byte_data)
                        8'h01:   state_nx = S_ADDR;
                        8'h02: begin
                            state_nx = S_DISCARD;
                            show_nx  = 1'b1;
                        end
                        8'h03:   state_nx = S_FR;
                        default: state_nx = S_DISCARD;
                    endcase
                end
                S_ADDR: begin
                    ptr_nx   = start_addr;
                    state_nx = S_RED;
                end
                S_RED: begin
                    red_nx   = byte_data;
                    state_nx = S_GRN;
                end
                S_GRN: begin
                    grn_nx   = byte_data;
                    state_nx = S_BLU;
                end
                S_BLU: begin
                    we_nx    = 1'b1;
                    addr_nx  = ptr;
                    wdata_nx = {grn, red, byte_data};
                    ptr_nx   = (ptr == LAST) ? '0 : ptr + 1'b1;
                    state_nx = S_RED;
                end
                S_FR: begin
                    red_nx   = byte_data;
                    state_nx = S_FG;
                end
                S_FG: begin
                    grn_nx   = byte_data;
                    state_nx = S_FB;
                end
                S_FB: begin
                    we_nx    = 1'b1;
                    busy_nx  = 1'b1;
                    addr_nx  = '0;
                    wdata_nx = {grn, red, byte_data};
                    state_nx = S_FILLING;
                end
                default: state_nx = cur;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_CMD;
            ptr        <= '0;
            red        <= '0;
            grn        <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            frame_show <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            red        <= red_nx;
            grn        <= grn_nx;
            mem_we     <= we_nx;
            mem_addr   <= addr_nx;
            mem_wdata  <= wdata_nx;
            frame_show <= show_nx;
            busy       <= busy_nx;
            overrun    <= overrun_nx;
        end
    end

endmodule

// File: tb/tb_spi_pixel_writer.sv
// Randomized and directed bench for spi_pixel_writer against a transaction-level model.
module tb_spi_pixel_writer;

    localparam int NL = 64;
    localparam int AW = 6;

    logic          clk;
    logic          resetn;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_idle;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_wdata;
    logic          frame_show;
    logic          busy;
    logic          overrun;

    spi_pixel_writer #(.NUM_LEDS(NL), .ADDR_W(AW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_idle  (byte_idle),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .frame_show (frame_show),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the transaction is a list of bytes since the last idle; each byte's
    // effect follows from its index within that list and the command byte.
    bit         model_ok = 0;
    int         n, cmd, ptr, fill_idx;
    bit         fill_on;
    logic [7:0] r, g;
    bit         exp_we, exp_show, exp_busy, exp_overrun;
    int         exp_addr;
    logic [23:0] exp_wdata;
    int         mlog_addr[$];
    logic [23:0] mlog_data[$];

    always @(posedge clk) begin
        logic [7:0] b;
        model_ok = 1;
        exp_we   = 0;
        exp_show = 0;
        exp_busy = 0;
        b        = byte_data;
        if (!resetn) begin
            n = 0; cmd = 0; ptr = 0; fill_on = 0; fill_idx = 0;
            r = 0; g = 0;
            exp_addr = 0; exp_wdata = 0; exp_overrun = 0;
        end else if (fill_on) begin
            if (byte_valid) exp_overrun = 1;
            if (fill_idx < NL) begin
                exp_we = 1; exp_busy = 1; exp_addr = fill_idx;
                mlog_addr.push_back(exp_addr); mlog_data.push_back(exp_wdata);
                fill_idx++;
            end else begin
                fill_on = 0;
            end
        end else begin
            if (byte_idle) n = 0;
            if (byte_valid) begin
                if (n == 0) begin
                    cmd = b;
                    if (b == 8'h02) exp_show = 1;
                end else if (cmd == 1) begin
                    if (n == 1) begin
                        ptr = b & ((1 << AW) - 1);
                        if (ptr >= NL) ptr = 0;
                    end else begin
                        case ((n - 2) % 3)
                            0: r = b;
                            1: g = b;
                            default: begin
                                exp_we = 1; exp_addr = ptr; exp_wdata = {g, r, b};
                                mlog_addr.push_back(exp_addr); mlog_data.push_back(exp_wdata);
                                ptr = (ptr + 1) % NL;
                            end
                        endcase
                    end
                end else if (cmd == 3) begin
                    if (n == 1) r = b;
                    else if (n == 2) g = b;
                    else if (n == 3) begin
                        exp_we = 1; exp_busy = 1; exp_addr = 0; exp_wdata = {g, r, b};
                        mlog_addr.push_back(0); mlog_data.push_back(exp_wdata);
                        fill_on = 1; fill_idx = 1;
                    end
                end
                n++;
            end
        end
    end

    int          dlog_addr[$];
    logic [23:0] dlog_data[$];
    int          show_cnt, busy_cnt;

    always @(negedge clk) begin
        if (model_ok) begin
            check("mem_we", 32'(mem_we), 32'(exp_we));
            check("frame_show", 32'(frame_show), 32'(exp_show));
            check("busy", 32'(busy), 32'(exp_busy));
            check("overrun", 32'(overrun), 32'(exp_overrun));
            if (exp_we) begin
                check("mem_addr", 32'(mem_addr), 32'(exp_addr));
                check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
            end
        end
        if (mem_we === 1'b1) begin
            dlog_addr.push_back(int'(mem_addr));
            dlog_data.push_back(mem_wdata);
        end
        if (frame_show === 1'b1) show_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic idle = 1'b0);
        byte_valid = 1'b1;
        byte_data  = b;
        byte_idle  = idle;
        tick();
        byte_valid = 1'b0;
        byte_idle  = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    task automatic idle_n(input int cycles);
        byte_idle = 1'b1;
        repeat (cycles) tick();
        byte_idle = 1'b0;
    endtask

    task automatic send_list(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send(bytes[i]);
    endtask

    task automatic clear_logs();
        dlog_addr.delete(); dlog_data.delete();
        mlog_addr.delete(); mlog_data.delete();
        show_cnt = 0; busy_cnt = 0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; byte_valid = 1'b0; byte_data = '0; byte_idle = 1'b1;
        repeat (3) tick();
        check("rst_we", 32'(mem_we), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        check("rst_show", 32'(frame_show), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        resetn = 1'b1;
        idle_n(2);

        // Two triplets from address 5.
        clear_logs();
        send_list('{8'h01, 8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60});
        repeat (2) tick();
        check("t1_model_cnt", 32'(mlog_addr.size()), 2);
        check("t1_cnt", 32'(dlog_addr.size()), 2);
        if (dlog_addr.size() == 2) begin
            check("t1_addr0", 32'(dlog_addr[0]), 5);
            check("t1_data0", 32'(dlog_data[0]), 32'h201030);
            check("t1_addr1", 32'(dlog_addr[1]), 6);
            check("t1_data1", 32'(dlog_data[1]), 32'h504060);
        end

        // Pointer wrap from the last pixel.
        idle_n(1); clear_logs();
        send_list('{8'h01, 8'h3F, 8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22, 8'h33});
        repeat (2) tick();
        check("t2_cnt", 32'(dlog_addr.size()), 2);
        if (dlog_addr.size() == 2) begin
            check("t2_addr0", 32'(dlog_addr[0]), 63);
            check("t2_data0", 32'(dlog_data[0]), 32'hBBAACC);
            check("t2_addr1", 32'(dlog_addr[1]), 0);
            check("t2_data1", 32'(dlog_data[1]), 32'h221133);
        end

        // Fill with a byte injected mid-fill.
        idle_n(1); clear_logs();
        send_list('{8'h03, 8'h01, 8'h02, 8'h03});
        repeat (20) tick();
        send(8'h77);
        repeat (50) tick();
        check("t3_model_cnt", 32'(mlog_addr.size()), NL);
        check("t3_cnt", 32'(dlog_addr.size()), NL);
        check("t3_busy_cycles", 32'(busy_cnt), NL);
        check("t3_overrun", 32'(overrun), 1);
        begin
            int bad = 0;
            foreach (dlog_addr[i])
                if (dlog_addr[i] != i || dlog_data[i] != 24'h020103) bad++;
            check("t3_fill_pattern", 32'(bad), 0);
        end

        // SHOW, then the rest of the transaction is ignored.
        idle_n(1); clear_logs();
        send_list('{8'h02, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'hFF});
        tick();
        check("t4_show_cnt", 32'(show_cnt), 1);
        check("t4_no_write", 32'(dlog_addr.size()), 0);
        idle_n(1);
        send_list('{8'h01, 8'h00, 8'hFF, 8'hFF, 8'hFF});
        tick();
        check("t4_write_cnt", 32'(dlog_addr.size()), 1);
        if (dlog_addr.size() == 1) begin
            check("t4_addr", 32'(dlog_addr[0]), 0);
            check("t4_data", 32'(dlog_data[0]), 32'hFFFFFF);
        end

        // Idle mid-triplet aborts the pixel.
        idle_n(1); clear_logs();
        send_list('{8'h01, 8'h00, 8'h11, 8'h22});
        idle_n(1);
        send_list('{8'h33, 8'h44, 8'h55});
        repeat (2) tick();
        check("t5_no_write", 32'(dlog_addr.size()), 0);

        // Reset in the middle of a fill.
        idle_n(1); clear_logs();
        send_list('{8'h03, 8'h01, 8'h02, 8'h03});
        repeat (10) tick();
        check("t6_addr_before_rst", 32'(mem_addr), 10);
        resetn = 1'b0;
        tick();
        check("t6_we_rst", 32'(mem_we), 0);
        check("t6_busy_rst", 32'(busy), 0);
        check("t6_overrun_rst", 32'(overrun), 0);
        repeat (2) tick();
        resetn = 1'b1;
        clear_logs();
        idle_n(1);
        send(8'h02);
        tick();
        check("t6_show_after_rst", 32'(show_cnt), 1);
        check("t6_no_write_after_rst", 32'(dlog_addr.size()), 0);

        // Randomized transactions.
        repeat (300) begin
            int sel, len;
            logic [7:0] c;
            if ($urandom_range(0, 40) == 0) begin
                resetn = 1'b0;
                repeat (2) tick();
                resetn = 1'b1;
            end
            sel = $urandom_range(0, 9);
            if (sel < 4) c = 8'h01;
            else if (sel < 6) c = 8'h02;
            else if (sel < 8) c = 8'h03;
            else c = 8'($urandom);
            if ($urandom_range(0, 3) == 0) send(c, 1'b1);
            else begin
                idle_n($urandom_range(1, 2));
                send(c);
            end
            len = (c == 8'h01) ? $urandom_range(1, 11) : $urandom_range(0, 5);
            repeat (len) begin
                repeat ($urandom_range(0, 2)) tick();
                send(8'($urandom_range(0, 255)));
            end
            if (c == 8'h03 && $urandom_range(0, 1) == 1) repeat (70) tick();
        end
        idle_n(2);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
